// File: rtl/board_scan_attack_ctrl.sv
// Naval-battle board controller: ship/attack planes, debounced command execution and LED scan.
// Optional macro BLINK_HIT_EN makes hit cells blink in attack and review modes.
`timescale 1ns / 1ps

module board_scan_attack_ctrl #(
    parameter int ROWS       = 7,
    parameter int COLS       = 5,
    parameter int SCAN_DIV   = 16,
    parameter int DEB_CYCLES = 250000,
    localparam int RW        = $clog2(ROWS),
    localparam int CW        = $clog2(COLS),
    localparam int CNTW      = $clog2(ROWS * COLS + 1)
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [1:0]      mode,
    input  logic [RW-1:0]   coord_row,
    input  logic [CW-1:0]   coord_col,
    input  logic            button_confirmation,
    output logic [COLS-1:0] m_col,
    output logic [ROWS-1:0] m_line,
    output logic [1:0]      result,
    output logic            result_valid,
    output logic [CNTW-1:0] ship_count,
    output logic [CNTW-1:0] hit_count,
    output logic            game_over
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [CNTW-1:0] MaxCnt = CNTW'(ROWS * COLS);

    typedef enum logic [1:0] {StWaitPress, StApply, StWaitRelease} state_e;

    // Button synchronizer and debouncer
    logic          sync0_q, sync1_q, deb_q, press_q;
    logic [DW-1:0] deb_cnt_q;

    always_ff @(posedge clk) begin
        if (!clr) begin
            sync0_q   <= 1'b0;
            sync1_q   <= 1'b0;
            deb_q     <= 1'b0;
            press_q   <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync0_q <= button_confirmation;
            sync1_q <= sync0_q;
            press_q <= 1'b0;
            if (sync1_q == deb_q) begin
                deb_cnt_q <= '0;
            end else if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
                deb_q     <= sync1_q;
                press_q   <= sync1_q;
                deb_cnt_q <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + 1'b1;
            end
        end
    end

    // Command FSM and board state
    state_e          state_q, state_d;
    logic [COLS-1:0] ship_q [ROWS];
    logic [COLS-1:0] ship_d [ROWS];
    logic [COLS-1:0] atk_q  [ROWS];
    logic [COLS-1:0] atk_d  [ROWS];
    logic [CNTW-1:0] ship_cnt_q, ship_cnt_d, hit_cnt_q, hit_cnt_d;
    logic [1:0]      result_q, result_d;
    logic            valid_q, valid_d;
    logic            in_range;

    always_comb begin
        state_d    = state_q;
        ship_d     = ship_q;
        atk_d      = atk_q;
        ship_cnt_d = ship_cnt_q;
        hit_cnt_d  = hit_cnt_q;
        result_d   = result_q;
        valid_d    = 1'b0;
        in_range   = (int'(coord_row) < ROWS) && (int'(coord_col) < COLS);
        unique case (state_q)
            StWaitPress: if (press_q) state_d = StApply;
            StApply: begin
                state_d = StWaitRelease;
                case (mode)
                    2'b00: begin
                        ship_d     = '{default: '0};
                        atk_d      = '{default: '0};
                        ship_cnt_d = '0;
                        hit_cnt_d  = '0;
                        result_d   = 2'b00;
                    end
                    2'b01: begin
                        valid_d = 1'b1;
                        if (!in_range) begin
                            result_d = 2'b11;
                        end else begin
                            result_d = 2'b00;
                            if (ship_q[coord_row][coord_col]) begin
                                ship_d[coord_row][coord_col] = 1'b0;
                                if (ship_cnt_q != '0) ship_cnt_d = ship_cnt_q - 1'b1;
                                // A removed ship cannot stay hit
                                if (atk_q[coord_row][coord_col]) begin
                                    atk_d[coord_row][coord_col] = 1'b0;
                                    if (hit_cnt_q != '0) hit_cnt_d = hit_cnt_q - 1'b1;
                                end
                            end else begin
                                ship_d[coord_row][coord_col] = 1'b1;
                                if (ship_cnt_q != MaxCnt) ship_cnt_d = ship_cnt_q + 1'b1;
                            end
                        end
                    end
                    2'b10: begin
                        valid_d = 1'b1;
                        if (!in_range) begin
                            result_d = 2'b11;
                        end else if (atk_q[coord_row][coord_col]) begin
                            result_d = 2'b10;
                        end else begin
                            atk_d[coord_row][coord_col] = 1'b1;
                            if (ship_q[coord_row][coord_col]) begin
                                result_d = 2'b01;
                                if (hit_cnt_q != MaxCnt) hit_cnt_d = hit_cnt_q + 1'b1;
                            end else begin
                                result_d = 2'b00;
                            end
                        end
                    end
                    default: begin
                        valid_d  = 1'b1;
                        result_d = 2'b11;
                    end
                endcase
            end
            StWaitRelease: if (!deb_q) state_d = StWaitPress;
            default: state_d = StWaitPress;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q    <= StWaitPress;
            ship_q     <= '{default: '0};
            atk_q      <= '{default: '0};
            ship_cnt_q <= '0;
            hit_cnt_q  <= '0;
            result_q   <= 2'b00;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ship_q     <= ship_d;
            atk_q      <= atk_d;
            ship_cnt_q <= ship_cnt_d;
            hit_cnt_q  <= hit_cnt_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
        end
    end

    // LED matrix scan
    logic [SCAN_DIV-1:0] presc_q;
    logic [CW-1:0]       col_q;
    logic [COLS-1:0]     col_oh;
    logic [ROWS-1:0]     line_bits;
    logic                blink_on;

`ifdef BLINK_HIT_EN
    logic [SCAN_DIV+5:0] blink_q;

    always_ff @(posedge clk) begin
        if (!clr) blink_q <= '0;
        else      blink_q <= blink_q + 1'b1;
    end

    assign blink_on = blink_q[SCAN_DIV+5];
`else
    assign blink_on = 1'b1;
`endif

    always_comb begin
        col_oh    = '0;
        line_bits = '0;
        for (int c = 0; c < COLS; c++) col_oh[c] = (int'(col_q) == c);
        for (int r = 0; r < ROWS; r++) begin
            case (mode)
                2'b00:   line_bits[r] = 1'b0;
                2'b01:   line_bits[r] = ship_q[r][col_q];
                2'b10:   line_bits[r] = atk_q[r][col_q];
                default: line_bits[r] = ship_q[r][col_q] | atk_q[r][col_q];
            endcase
            if (mode[1] && ship_q[r][col_q] && atk_q[r][col_q] && !blink_on) line_bits[r] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            presc_q <= '0;
            col_q   <= '0;
            m_col   <= COLS'(1);
            m_line  <= '1;
        end else begin
            presc_q <= presc_q + 1'b1;
            if (&presc_q) col_q <= (int'(col_q) == COLS - 1) ? '0 : col_q + 1'b1;
            m_col  <= col_oh;
            m_line <= ~line_bits;
        end
    end

    assign result       = result_q;
    assign result_valid = valid_q;
    assign ship_count   = ship_cnt_q;
    assign hit_count    = hit_cnt_q;
    assign game_over    = (hit_cnt_q == ship_cnt_q) && (ship_cnt_q != '0);

endmodule

// File: doc/board_scan_attack_ctrl.md
Name: board_scan_attack_ctrl

Overview:
Parametrised board controller for the naval-battle game. It stores a ROWS x COLS ship-placement plane and an attack plane, and applies confirmed place and attack commands. It classifies each shot as HIT, MISS, REPEAT or INVALID, and counts ships and hits. It also time-multiplexes either plane onto the LED matrix column/line drivers, replacing the fixed 7x5 register, mux and demux datapath used at top level.

Parameters:
ROWS, 7, matrix lines (2..16)
COLS, 5, matrix columns (2..16)
SCAN_DIV, 16, prescaler width; column advances every 2^SCAN_DIV clk cycles
DEB_CYCLES, 250000, clk cycles the synchronized button must be stable before accepted
RW, $clog2(ROWS), row coordinate width (derived, localparam)
CW, $clog2(COLS), column coordinate width (derived, localparam)

Ports:
clk  in  1  system clock
clr  in  1  synchronous reset, active-low
mode  in  2  00 clear, 01 placement, 10 attack, 11 review
coord_row  in  RW  target line
coord_col  in  CW  target column
button_confirmation  in  1  raw confirm button, active-high, asynchronous
m_col  out  COLS  column drive, one-hot active-high
m_line  out  ROWS  line drive, active-low (0 = LED lit)
result  out  2  00 MISS, 01 HIT, 10 REPEAT, 11 INVALID
result_valid  out  1  one-cycle pulse when result updates
ship_count  out  $clog2(ROWS*COLS+1)  cells holding a ship
hit_count  out  $clog2(ROWS*COLS+1)  cells hit
game_over  out  1  high while hit_count == ship_count and ship_count != 0

Behaviour:
- Reset (clr == 0 at a clk edge): clear both planes and both counters; result = 00; result_valid = 0; game_over = 0; FSM to WAIT_PRESS; scan column = 0; m_col = 1 (column 0); m_line = all 1s. Reset mid-debounce or mid-FSM aborts the press with no plane update.
- Button path:
  - 2-flop synchronizer, then stability counter. A level is accepted after DEB_CYCLES consecutive equal samples.
  - Any change restarts the count.
  - An accepted 0->1 transition produces one internal press pulse.
- FSM states:
  - WAIT_PRESS: on press -> APPLY.
  - APPLY: one cycle; updates planes/counters per mode; -> WAIT_RELEASE.
  - WAIT_RELEASE: -> WAIT_PRESS when the debounced level is 0.
  - Exactly one command executes per physical press.
- APPLY per mode; coordinates sampled in APPLY:
  - 00: clear both planes and counters; result = 00; no result_valid.
  - 01 (placement): coord_row >= ROWS or coord_col >= COLS -> result 11. Otherwise toggle the ship bit and adjust ship_count by ±1. Removing a ship that is already hit also decrements hit_count and clears that hit bit. result = 00.
  - 10 (attack): out of range -> 11. Attack bit already set -> 10, no state change. Otherwise set the attack bit; ship bit = 1 -> 01 and hit_count += 1; ship bit = 0 -> 00.
  - 11 (review): no update; result = 11.
- result_valid pulses in the cycle after APPLY (modes 01, 10, 11); result holds until the next APPLY. Latency from accepted press to result_valid is 2 clk cycles.
- Counters saturate at ROWS*COLS and never wrap. game_over is combinational from the registered counters.
- Scan:
  - A prescaler counts continuously. On wrap, the column index advances, COLS-1 -> 0.
  - m_col = one-hot(column index).
  - m_line[r] = ~plane bit(r, column index), where the plane bit is:
    - mode 00: 0 (all LEDs off)
    - mode 01: ship
    - mode 10: attack
    - mode 11: ship OR attack
  - Outputs are registered, so columns and lines change on the same edge.
- A mode change mid-FSM does not abort a command: APPLY uses the mode present in its own cycle.

Optional Feature:
BLINK_HIT_EN
- When defined, in modes 10 and 11 cells with ship AND attack set blink. They are gated by the MSB of an extra 2^(SCAN_DIV+6) counter, cleared on reset.
- When undefined, hit cells are lit steadily. No extra counter is synthesized.

Test Plan:
- Reset with clr = 0 for 2 cycles -> m_col = 5'b00001, m_line = 7'h7F, result = 00, counts = 0, game_over = 0.
- Mode 01, coords (2,3), press held longer than DEB_CYCLES -> ship_count = 1, result = 00. result_valid pulses once, exactly 2 cycles after debounce acceptance.
- Mode 10, shot at (2,3) -> result = 01, hit_count = 1, game_over = 1. Second shot at (2,3) -> result = 10, hit_count stays 1. Shot at (0,0) -> result = 00.
- Coords (7,0) with ROWS = 7 in mode 10 -> result = 11, planes unchanged. Button bouncing shorter than DEB_CYCLES -> no result_valid.
- Mode 11 with SCAN_DIV = 2 -> the column advances every 4 cycles, wraps from 4 to 0, and m_line = ~(ship|attack) for each column. Mode 00 + press -> counts = 0 and all lines = 1.
- Reset asserted during WAIT_RELEASE after a hit -> counters 0; the next press is processed normally.
